uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first; receive side of the serial link clocked by BaudRate.
//  Samples rxd using the 8x-oversample toggle bclk_8 from BaudRate, in the clk domain.
//  Recovers bytes, flags framing and overrun errors, and holds each byte until host acks via rd.
// PARAMETERS
//  DATA_BITS    8  payload bits per frame
//  OVS          8  ticks per bit; must equal BaudRate's bclk_8:bclk ratio
//  SYNC_STAGES  2  synchronizer flops on rxd (>=2)
// PORTS
//  clk          in   1          system clock; all logic on posedge clk
//  rst_n        in   1          reset, synchronous, active-low
//  bclk_8       in   1          BaudRate 8x toggle output (level, not a strobe)
//  rxd          in   1          serial line; idles high; asynchronous to clk
//  rd           in   1          host read ack; clears rx_valid
//  clr_err      in   1          clears frame_err and overrun_err
//  rx_data      out  DATA_BITS  last good byte
//  rx_valid     out  1          rx_data holds an unread byte
//  frame_err    out  1          sticky: stop bit sampled low
//  overrun_err  out  1          sticky: new byte overwrote an unread one
//  busy         out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, state=IDLE, sync flops=1, bclk_8_q=0.
//    Mid-frame reset abandons the frame; no partial byte is delivered.
//  tick = bclk_8 & ~bclk_8_q, where bclk_8_q is bclk_8 registered: one clk pulse per bclk_8 rising edge.
//    OVS ticks make one bit time.
//  rxd_s = rxd after SYNC_STAGES flops. All line decisions use rxd_s on tick cycles only.
//  cnt: 3-bit tick counter; bit_idx: 0..DATA_BITS-1; shreg: DATA_BITS shift register.
//  FSM transitions (evaluated on tick cycles only):
//   IDLE:      rxd_s==0 -> START, cnt<=0.
//   START:     cnt!=OVS/2-1 -> cnt++.
//              cnt==OVS/2-1 (mid-bit) and rxd_s==0 -> DATA, cnt<=0, bit_idx<=0.
//              cnt==OVS/2-1 and rxd_s==1 -> IDLE (glitch; no flag raised).
//   DATA:      cnt!=OVS-1 -> cnt++.
//              cnt==OVS-1 -> shreg<={rxd_s,shreg[DATA_BITS-1:1]}, cnt<=0, bit_idx++.
//              After bit DATA_BITS-1 -> STOP.
//   STOP:      cnt==OVS-1 and rxd_s==1 -> deliver, then IDLE.
//              cnt==OVS-1 and rxd_s==0 -> frame_err<=1, no delivery, -> BREAK.
//   BREAK:     rxd_s==1 -> IDLE. Prevents a held-low line from retriggering.
//  Deliver: rx_data<=shreg; rx_valid<=1.
//    If rx_valid==1 and rd==0 on the same cycle, overrun_err<=1 and data is overwritten.
//  rd: rx_valid<=0 the next cycle unless a delivery occurs in that same cycle.
//    Delivery wins: rx_valid stays 1, no overrun.
//  clr_err clears both error flags next cycle. A simultaneous set wins: flag stays 1.
//  rd while rx_valid==0: no effect. rx_data holds its value when rx_valid drops.
//  Latency: rx_valid rises 1 clk after the stop-bit sampling tick.
//  Width rules: cnt wraps only via explicit reset to 0, never by overflow.
//    bit_idx is sized $clog2(DATA_BITS)+1.
// STRUCTURE
//  uart_defs.vh (shared with a future uart_tx): state encodings IDLE=0, START=1, DATA=2,
//    STOP=3, BREAK=4; UART_OVS=8; UART_DATA_BITS=8.
//  One sub-module, uart_rx_sync: the rxd synchronizer chain plus bclk_8 edge detector.
//    Outputs rxd_s and tick. The FSM and datapath stay in uart_rx.
// TESTING
//  Drive bclk_8 from BaudRate with b_sel=2'b01: bclk_8 period 1304 clk, bit time 10432 clk.
//  1 Send 0xA5 with a good stop bit -> rx_data=8'hA5, rx_valid=1, frame_err=0, busy=0.
//      Then pulse rd -> rx_valid=0 on the next cycle.
//  2 Pulse rxd low for 2 ticks, then high -> return to IDLE, rx_valid=0, frame_err=0.
//  3 Send 0x3C with the stop bit low, then hold rxd low for 3 bit times, then release
//      -> frame_err=1, rx_valid=0, FSM held in BREAK until release.
//      Then 0x81 -> rx_data=8'h81.
//  4 Send 0x11 then 0x22 with no rd -> rx_data=8'h22, overrun_err=1.
//      clr_err -> overrun_err=0.
//  5 Assert rd on the exact delivery cycle of a second byte -> rx_valid stays 1, overrun_err=0.
//  6 Assert rst_n=0 during bit 4 of 0xFF, release, then send 0x5A
//      -> only 0x5A is delivered; all outputs are 0 during reset.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants.
// Kept separate so a future transmitter can use the same encodings.
package uart_rx_pkg;

  localparam int UART_OVS       = 8;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Width of a tick counter that must reach ovs-1 without wrapping.
  function automatic int cnt_width(input int ovs);
    return (ovs > 2) ? $clog2(ovs) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchronizer chain plus rising-edge detector that turns the bclk_8
// toggle into a single-cycle tick in the clk domain.
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rxd,
  input  logic i_bclk_8,
  output logic o_rxd_s,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_bclk_8_q;

  // Line idles high, so the chain resets to 1 to avoid a false start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_bclk_8_q <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_bclk_8_q <= i_bclk_8;
    end
  end

  assign o_rxd_s = r_sync[SYNC_STAGES-1];
  assign o_tick  = i_bclk_8 & ~r_bclk_8_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling on 8x oversample ticks, sticky framing
// and overrun flags, and a holding register acknowledged by rd.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVS         = UART_OVS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bclk_8,
  input  logic                 rxd,
  input  logic                 rd,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(OVS);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic w_rxd_s;
  logic w_tick;
  logic w_stop_tick;
  logic w_deliver;
  logic w_frame_bad;

  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rxd    (rxd),
    .i_bclk_8 (bclk_8),
    .o_rxd_s  (w_rxd_s),
    .o_tick   (w_tick)
  );

  assign w_stop_tick = w_tick && (r_state == ST_STOP) && (r_cnt == CNT_LAST);
  assign w_deliver   = w_stop_tick &  w_rxd_s;
  assign w_frame_bad = w_stop_tick & ~w_rxd_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      // A delivery on the same cycle as rd keeps the new byte valid.
      if (w_deliver) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (rd) begin
        r_rx_valid <= 1'b0;
      end

      if (w_deliver && r_rx_valid && !rd) begin
        r_overrun_err <= 1'b1;
      end else if (clr_err) begin
        r_overrun_err <= 1'b0;
      end

      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end

      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_rxd_s) begin
              r_state <= ST_START;
              r_cnt   <= '0;
            end
          end
          ST_START: begin
            if (r_cnt != CNT_MID) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_rxd_s) begin
              r_state   <= ST_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (r_cnt != CNT_LAST) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_shreg   <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
              r_cnt     <= '0;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              if (r_bit_idx == IDX_LAST) begin
                r_state <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            if (r_cnt != CNT_LAST) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt   <= '0;
              r_state <= w_rxd_s ? ST_IDLE : ST_BREAK;
            end
          end
          // Held-low line must return high before a new start bit is accepted.
          ST_BREAK: begin
            if (w_rxd_s) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bclk_8 toggles every 2 clk (bit time 32 clk),
// frames are aligned to a bclk_8 falling edge so delivery timing is exact.
module tb_uart_rx;

  localparam int BIT_NS = 320;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       bclk_8  = 1'b0;
  logic       rxd     = 1'b1;
  logic       rd      = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  uart_rx #(
    .DATA_BITS   (8),
    .OVS         (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk_8      (bclk_8),
    .rxd         (rxd),
    .rd          (rd),
    .clr_err     (clr_err),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5  clk    = ~clk;
  always #20 bclk_8 = ~bclk_8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start bit falls at the call time T; stop-bit sample and delivery land at T+3065.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(BIT_NS);
    end
    rxd = stop_bit;
    #(BIT_NS);
    rxd = 1'b1;
  endtask

  task automatic align();
    @(negedge bclk_8);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_oerr", overrun_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS);

    // 1: good frame 0xA5, exact delivery latency, then rd
    align();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        #3061;
        chk("t1_valid_before", rx_valid, 1'b0);
        chk("t1_busy_during", busy, 1'b1);
        #5;
        chk("t1_valid_edge", rx_valid, 1'b1);
        chk("t1_data_edge", rx_data, 8'hA5);
      end
    join
    #(BIT_NS);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_valid", rx_valid, 1'b1);
    chk("t1_ferr", frame_err, 1'b0);
    chk("t1_busy", busy, 1'b0);
    pulse_rd();
    chk("t1_rd_valid", rx_valid, 1'b0);
    chk("t1_rd_hold", rx_data, 8'hA5);

    // 2: two-tick glitch is rejected at the mid-start check
    align();
    rxd = 1'b0;
    #80;
    rxd = 1'b1;
    #1;
    chk("t2_busy_glitch", busy, 1'b1);
    #(BIT_NS);
    chk("t2_busy", busy, 1'b0);
    chk("t2_valid", rx_valid, 1'b0);
    chk("t2_ferr", frame_err, 1'b0);

    // 3: bad stop bit, line held low three bit times, then 0x81
    align();
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    #300;
    chk("t3_ferr", frame_err, 1'b1);
    chk("t3_valid", rx_valid, 1'b0);
    chk("t3_busy_break", busy, 1'b1);
    #(3 * BIT_NS - 310);
    chk("t3_busy_hold", busy, 1'b1);
    #10;
    rxd = 1'b1;
    #100;
    chk("t3_busy_release", busy, 1'b0);
    chk("t3_ferr_sticky", frame_err, 1'b1);
    align();
    send_frame(8'h81, 1'b1);
    #(BIT_NS);
    chk("t3_data81", rx_data, 8'h81);
    chk("t3_valid81", rx_valid, 1'b1);
    pulse_clr();
    chk("t3_ferr_clr", frame_err, 1'b0);
    pulse_rd();
    chk("t3_rd_valid", rx_valid, 1'b0);

    // 4: overrun from two unread bytes, then clr_err
    align();
    send_frame(8'h11, 1'b1);
    #(BIT_NS);
    chk("t4_data11", rx_data, 8'h11);
    chk("t4_oerr_first", overrun_err, 1'b0);
    align();
    send_frame(8'h22, 1'b1);
    #(BIT_NS);
    chk("t4_data22", rx_data, 8'h22);
    chk("t4_valid22", rx_valid, 1'b1);
    chk("t4_oerr", overrun_err, 1'b1);
    pulse_clr();
    chk("t4_oerr_clr", overrun_err, 1'b0);
    pulse_rd();
    chk("t4_rd_valid", rx_valid, 1'b0);

    // 5: rd on the exact delivery cycle of a second byte
    align();
    send_frame(8'h33, 1'b1);
    #(BIT_NS);
    chk("t5_valid33", rx_valid, 1'b1);
    align();
    fork
      send_frame(8'h44, 1'b1);
      begin
        #3060;
        rd = 1'b1;
        #6;
        chk("t5_valid_edge", rx_valid, 1'b1);
        #4;
        rd = 1'b0;
      end
    join
    #(BIT_NS);
    chk("t5_data44", rx_data, 8'h44);
    chk("t5_valid", rx_valid, 1'b1);
    chk("t5_oerr", overrun_err, 1'b0);

    // 6: reset during bit 4 of 0xFF, then 0x5A
    align();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        #1700;
        rst_n = 1'b0;
        #16;
        chk("t6_rst_data", rx_data, 8'h00);
        chk("t6_rst_valid", rx_valid, 1'b0);
        chk("t6_rst_ferr", frame_err, 1'b0);
        chk("t6_rst_oerr", overrun_err, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        #4;
        rst_n = 1'b1;
      end
    join
    #(BIT_NS);
    chk("t6_no_partial", rx_valid, 1'b0);
    chk("t6_idle", busy, 1'b0);
    align();
    send_frame(8'h5A, 1'b1);
    #(BIT_NS);
    chk("t6_data5a", rx_data, 8'h5A);
    chk("t6_valid5a", rx_valid, 1'b1);
    chk("t6_ferr", frame_err, 1'b0);
    chk("t6_oerr", overrun_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
